// File: rtl/merge_logic_demux_nx_pkg.sv
// Shared state encoding and latency helpers for the root merge-logic demux.
package merge_logic_demux_nx_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_P1, ST_P2, ST_PEND, ST_DRAIN} demux_state_e;

  function automatic int log2_ceil(input int value);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Pipeline depth of the upstream merge logic; bounds how many bundles arrive after o_ml_read drops.
  function automatic int ml_latency(input int bundle_width);
    return (bundle_width <= 1) ? 1 : 2 * (log2_ceil(bundle_width) + 1) + 2;
  endfunction

  function automatic int cp_latency(input int bundle_width);
    return (bundle_width <= 1) ? 1 : ml_latency(bundle_width) / 2;
  endfunction

endpackage

// File: rtl/merge_logic_demux_nx_fifo.sv
// Generic FIFO: head visible 1 cycle after write; full reports no room this cycle, so a
// write alongside a pop at full is accepted; pop on empty is ignored and rd_dat reads 0.
module merge_logic_demux_nx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     rd_vld,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign rd_vld = (level != '0);
  assign pop    = rd_rdy & rd_vld;
  assign full   = (level == LVW'(DEPTH)) & ~pop;
  assign push   = wr_vld & ~full;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVW'(push) - LVW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/merge_logic_demux_nx.sv
// Steers {last,data} bundles to the phase-1 root FIFO or the phase-2 pairing coupler, switching only at run ends.
// Root head 1 cycle after write, coupler after the pair's 2nd write; o_ml_read throttles early, overflow drops.
module merge_logic_demux_nx
  import merge_logic_demux_nx_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int KEY_WIDTH    = 32,
  parameter int BUNDLE_WIDTH = 8,
  parameter int ROOT_DEPTH   = 32,
  parameter int CP_DEPTH     = 32,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_start,
  input  logic                                   i_phase_sel,
  input  logic [BUNDLE_WIDTH*DATA_WIDTH:0]       i_ml_data,
  input  logic                                   i_ml_data_vld,
  input  logic                                   i_root_read,
  input  logic                                   i_coupler_read,
  output logic                                   o_ml_read,
  output logic [BUNDLE_WIDTH*DATA_WIDTH:0]       o_root_data,
  output logic                                   o_root_data_vld,
  output logic [2*BUNDLE_WIDTH*DATA_WIDTH:0]     o_coupler_data,
  output logic                                   o_coupler_data_vld,
  output logic                                   o_phase,
  output logic                                   o_switch_busy,
  output logic                                   o_run_done,
  output logic [CNT_WIDTH-1:0]                   o_p1_cnt,
  output logic [CNT_WIDTH-1:0]                   o_p2_cnt,
  output logic                                   o_overflow
);
  localparam int LP_BW         = BUNDLE_WIDTH * DATA_WIDTH;
  localparam int LP_ML_LATENCY = ml_latency(BUNDLE_WIDTH);
  localparam int LP_CP_LATENCY = cp_latency(BUNDLE_WIDTH);
  localparam int LP_ROOT_THR   = ROOT_DEPTH - LP_ML_LATENCY - 1;
  localparam int LP_CP_THR     = CP_DEPTH - LP_CP_LATENCY - 1;
  localparam int LP_RLW        = $clog2(ROOT_DEPTH) + 1;
  localparam int LP_CLW        = $clog2(CP_DEPTH) + 1;
  localparam int LP_DCW        = $clog2(LP_ML_LATENCY + 1);

  if ((KEY_WIDTH > DATA_WIDTH) || ((BUNDLE_WIDTH & (BUNDLE_WIDTH - 1)) != 0) ||
      (ROOT_DEPTH < 2 * LP_ML_LATENCY) || (CP_DEPTH < 2 * LP_CP_LATENCY)) begin : g_bad_params
    $error("merge_logic_demux_nx: illegal parameter combination");
  end

  demux_state_e          state;
  logic [LP_DCW-1:0]     drain_cnt;
  logic                  ml_last;
  logic [LP_BW-1:0]      ml_dat;
  logic                  root_full;
  logic                  cp_full;
  logic                  root_prog_full;
  logic                  cp_prog_full;
  logic                  path_room;
  logic [LP_RLW-1:0]     root_level;
  logic [LP_CLW-1:0]     cp_level;
  logic                  wr_root;
  logic                  wr_cp;
  logic                  last_wr;
  logic                  cp_push;
  logic                  hold_vld;
  logic [LP_BW-1:0]      hold_dat;
  logic [2*LP_BW:0]      cp_word;

  assign ml_last = i_ml_data[LP_BW];
  assign ml_dat  = i_ml_data[LP_BW-1:0];

  // DRAIN keeps routing to the old path: those bundles are the tail of the previous run.
  assign wr_root = i_ml_data_vld & (state != ST_IDLE) & ~o_phase & ~root_full;
  assign wr_cp   = i_ml_data_vld & (state != ST_IDLE) &  o_phase & ~cp_full;
  assign last_wr = (wr_root | wr_cp) & ml_last;

  assign root_prog_full = root_level >= LP_RLW'(LP_ROOT_THR);
  assign cp_prog_full   = cp_level >= LP_CLW'(LP_CP_THR);
  assign path_room      = o_phase ? ~cp_prog_full : ~root_prog_full;

  // A lone last bundle closes the word with a zero upper half.
  assign cp_push = wr_cp & (hold_vld | ml_last);
  assign cp_word = hold_vld ? {ml_last, ml_dat, hold_dat} : {ml_last, {LP_BW{1'b0}}, ml_dat};

  merge_logic_demux_nx_fifo #(.WIDTH(LP_BW + 1), .DEPTH(ROOT_DEPTH)) u_root_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .wr_vld (wr_root),
    .wr_dat (i_ml_data),
    .rd_rdy (i_root_read),
    .rd_dat (o_root_data),
    .rd_vld (o_root_data_vld),
    .full   (root_full),
    .level  (root_level)
  );

  merge_logic_demux_nx_fifo #(.WIDTH(2 * LP_BW + 1), .DEPTH(CP_DEPTH)) u_coupler_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .wr_vld (cp_push),
    .wr_dat (cp_word),
    .rd_rdy (i_coupler_read),
    .rd_dat (o_coupler_data),
    .rd_vld (o_coupler_data_vld),
    .full   (cp_full),
    .level  (cp_level)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      o_phase       <= 1'b0;
      o_switch_busy <= 1'b0;
      o_ml_read     <= 1'b0;
      drain_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state     <= i_phase_sel ? ST_P2 : ST_P1;
            o_phase   <= i_phase_sel;
            o_ml_read <= i_phase_sel ? ~cp_prog_full : ~root_prog_full;
          end
        end
        ST_P1, ST_P2, ST_PEND: begin
          o_ml_read <= path_room;
          if (last_wr && (state == ST_PEND || i_phase_sel != o_phase)) begin
            state         <= ST_DRAIN;
            drain_cnt     <= LP_DCW'(LP_ML_LATENCY);
            o_switch_busy <= 1'b1;
            o_ml_read     <= 1'b0;
          end else if (state != ST_PEND && i_phase_sel != o_phase) begin
            state         <= ST_PEND;
            o_switch_busy <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (i_ml_data_vld) begin
            drain_cnt <= LP_DCW'(LP_ML_LATENCY);
          end else if (drain_cnt == LP_DCW'(1)) begin
            state         <= o_phase ? ST_P1 : ST_P2;
            o_phase       <= ~o_phase;
            o_switch_busy <= 1'b0;
            o_ml_read     <= o_phase ? ~root_prog_full : ~cp_prog_full;
            drain_cnt     <= '0;
          end else begin
            drain_cnt <= drain_cnt - LP_DCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (wr_cp) begin
      if (hold_vld || ml_last) begin
        hold_vld <= 1'b0;
      end else begin
        hold_vld <= 1'b1;
        hold_dat <= ml_dat;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_p1_cnt   <= '0;
      o_p2_cnt   <= '0;
      o_overflow <= 1'b0;
      o_run_done <= 1'b0;
    end else begin
      if (wr_root) o_p1_cnt <= o_p1_cnt + CNT_WIDTH'(1);
      if (wr_cp)   o_p2_cnt <= o_p2_cnt + CNT_WIDTH'(1);
      if (i_ml_data_vld && !(wr_root || wr_cp)) o_overflow <= 1'b1;
      o_run_done <= last_wr;
    end
  end

endmodule

// File: tb/tb_merge_logic_demux_nx.sv
// Directed bench with a queue-based reference model compared every cycle, plus literal spot checks.
module tb_merge_logic_demux_nx;
  localparam int DW = 8;
  localparam int BWN = 2;
  localparam int RD = 16;
  localparam int CD = 8;
  localparam int CW = 16;
  localparam int BW = BWN * DW;
  localparam int L  = 6;    // 2*(log2(2)+1)+2
  localparam int CL = 3;

  logic clk = 0;
  logic rst = 0;
  logic start = 0;
  logic phase_sel = 0;
  logic [BW:0] ml_data = '0;
  logic ml_vld = 0;
  logic root_read = 0;
  logic cp_read = 0;
  logic ml_read;
  logic [BW:0] root_data;
  logic root_vld;
  logic [2*BW:0] cp_data;
  logic cp_vld;
  logic phase, busy, run_done, overflow;
  logic [CW-1:0] p1_cnt, p2_cnt;

  merge_logic_demux_nx #(
    .DATA_WIDTH(DW), .KEY_WIDTH(4), .BUNDLE_WIDTH(BWN),
    .ROOT_DEPTH(RD), .CP_DEPTH(CD), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_phase_sel(phase_sel),
    .i_ml_data(ml_data), .i_ml_data_vld(ml_vld),
    .i_root_read(root_read), .i_coupler_read(cp_read),
    .o_ml_read(ml_read), .o_root_data(root_data), .o_root_data_vld(root_vld),
    .o_coupler_data(cp_data), .o_coupler_data_vld(cp_vld),
    .o_phase(phase), .o_switch_busy(busy), .o_run_done(run_done),
    .o_p1_cnt(p1_cnt), .o_p2_cnt(p2_cnt), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run modes described by what the switch protocol promises.
  typedef enum int {M_IDLE, M_RUN, M_WAIT, M_DRAIN} mode_t;
  mode_t m_mode;
  bit m_phase, m_ovf, m_done, m_ml_read, m_busy, m_hold_vld;
  int m_quiet, m_p1, m_p2;
  logic [BW-1:0] m_hold;
  logic [BW:0] root_q[$];
  logic [2*BW:0] cp_q[$];
  int rsz, csz;
  bit rpop, cpop, acc, lastw;
  logic [BW:0] dump_r;
  logic [2*BW:0] dump_c;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_phase = 0; m_ovf = 0; m_done = 0; m_ml_read = 0; m_busy = 0;
      m_hold_vld = 0; m_hold = '0; m_quiet = 0; m_p1 = 0; m_p2 = 0;
      root_q.delete(); cp_q.delete();
    end else begin
      rsz = root_q.size(); csz = cp_q.size();
      rpop = root_read && rsz > 0;
      cpop = cp_read && csz > 0;
      acc = 0;
      if (ml_vld) begin
        if (m_mode == M_IDLE) m_ovf = 1;
        else if (m_phase == 0 ? (rsz == RD && !rpop) : (csz == CD && !cpop)) m_ovf = 1;
        else acc = 1;
      end
      lastw = acc && ml_data[BW];
      if (rpop) dump_r = root_q.pop_front();
      if (cpop) dump_c = cp_q.pop_front();
      if (acc) begin
        if (m_phase == 0) begin
          root_q.push_back(ml_data); m_p1++;
        end else begin
          m_p2++;
          if (m_hold_vld) begin
            cp_q.push_back({lastw, ml_data[BW-1:0], m_hold}); m_hold_vld = 0;
          end else if (lastw) begin
            cp_q.push_back({1'b1, {BW{1'b0}}, ml_data[BW-1:0]});
          end else begin
            m_hold = ml_data[BW-1:0]; m_hold_vld = 1;
          end
        end
      end
      m_done = lastw;
      case (m_mode)
        M_IDLE:  if (start) begin m_mode = M_RUN; m_phase = phase_sel; end
        M_RUN:   if (phase_sel != m_phase) begin m_mode = lastw ? M_DRAIN : M_WAIT; m_quiet = 0; end
        M_WAIT:  if (lastw) begin m_mode = M_DRAIN; m_quiet = 0; end
        M_DRAIN: begin
          m_quiet = ml_vld ? 0 : m_quiet + 1;
          if (m_quiet == L) begin m_mode = M_RUN; m_phase = !m_phase; end
        end
        default: m_mode = M_IDLE;
      endcase
      m_busy = (m_mode == M_WAIT) || (m_mode == M_DRAIN);
      m_ml_read = (m_mode == M_RUN || m_mode == M_WAIT) &&
                  (m_phase == 0 ? (rsz < RD - L - 1) : (csz < CD - CL - 1));
    end
  end

  always @(negedge clk) begin
    if (run_done) done_pulses++;
    check("ml_read", 64'(ml_read), 64'(m_ml_read));
    check("phase", 64'(phase), 64'(m_phase));
    check("switch_busy", 64'(busy), 64'(m_busy));
    check("run_done", 64'(run_done), 64'(m_done));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("p1_cnt", 64'(p1_cnt), 64'(m_p1[CW-1:0]));
    check("p2_cnt", 64'(p2_cnt), 64'(m_p2[CW-1:0]));
    check("root_vld", 64'(root_vld), 64'(root_q.size() > 0));
    check("cp_vld", 64'(cp_vld), 64'(cp_q.size() > 0));
    if (root_q.size() > 0) check("root_data", 64'(root_data), 64'(root_q[0]));
    if (cp_q.size() > 0) check("cp_data", 64'(cp_data), 64'(cp_q[0]));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [BW-1:0] d, input logic last);
    ml_data = {last, d};
    ml_vld = 1;
    step();
    ml_vld = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    step();
  endtask

  task automatic start_run(input logic sel);
    phase_sel = sel;
    start = 1;
    step();
    start = 0;
    check("start_ml_read", 64'(ml_read), 64'(1));
    check("start_phase", 64'(phase), 64'(sel));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int n;
  int d0;
  logic [2*BW:0] exp_w;
  logic [BW-1:0] lo, hi;

  initial begin
    #1 rst = 1;
    step();
    step();
    rst = 0;
    step();
    check("rst_ml_read", 64'(ml_read), 64'(0));
    check("rst_p1_cnt", 64'(p1_cnt), 64'(0));
    check("rst_root_vld", 64'(root_vld), 64'(0));

    // Phase-1 run of 10 bundles.
    start_run(0);
    d0 = done_pulses;
    for (int i = 0; i < 10; i++) send(16'hA000 + 16'(i), i == 9);
    step();
    check("t1_done_pulses", 64'(done_pulses - d0), 64'(1));
    check("t1_p1_cnt", 64'(p1_cnt), 64'(10));
    root_read = 1;
    for (int k = 0; k < 10; k++) begin
      check("t1_root_head", 64'(root_data), 64'({k == 9, 16'hA000 + 16'(k)}));
      step();
    end
    root_read = 0;
    check("t1_root_empty", 64'(root_vld), 64'(0));

    // Phase-2 run of 7 bundles: odd tail gets a zero upper half.
    do_reset();
    start_run(1);
    for (int i = 0; i < 7; i++) send(16'hB000 + 16'(i), i == 6);
    step();
    check("t2_p2_cnt", 64'(p2_cnt), 64'(7));
    cp_read = 1;
    for (int k = 0; k < 4; k++) begin
      lo = 16'hB000 + 16'(2 * k);
      hi = (k < 3) ? 16'hB000 + 16'(2 * k + 1) : 16'h0000;
      exp_w = {k == 3, hi, lo};
      check("t2_cp_word", 64'(cp_data), 64'(exp_w));
      step();
    end
    cp_read = 0;
    check("t2_cp_empty", 64'(cp_vld), 64'(0));

    // Switch request mid-run: honoured only after the last bundle, then L quiet cycles.
    do_reset();
    start_run(0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) phase_sel = 1;
      send(16'hD000 + 16'(i), i == 7);
      if (i == 2) check("t3_pend_busy", 64'({busy, phase}), 64'(2'b10));
    end
    check("t3_drain_busy", 64'({busy, phase, ml_read}), 64'(3'b100));
    check("t3_p1_cnt", 64'(p1_cnt), 64'(8));
    n = 0;
    while (phase !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("t3_drain_cycles", 64'(n), 64'(L));
    check("t3_after_busy", 64'({busy, ml_read}), 64'(2'b01));
    send(16'hE000, 0);
    send(16'hE001, 1);
    check("t3_cp_word", 64'(cp_data), 64'({1'b1, 16'hE001, 16'hE000}));
    check("t3_counts", 64'({p1_cnt, p2_cnt}), 64'({16'd8, 16'd2}));

    // Credit threshold: upstream keeps sending while o_ml_read, then L late bundles.
    do_reset();
    start_run(0);
    n = 0;
    while (ml_read && n < 40) begin
      send(16'hC100 + 16'(n), 0);
      n++;
    end
    check("t4_sent_before_drop", 64'(n), 64'(10));
    for (int i = 0; i < L; i++) send(16'hC200 + 16'(i), 0);
    check("t4_no_overflow", 64'(overflow), 64'(0));
    check("t4_p1_cnt", 64'(p1_cnt), 64'(16));
    root_read = 1;
    send(16'hC300, 0);
    root_read = 0;
    check("t4_full_rdwr_ovf", 64'(overflow), 64'(0));
    check("t4_full_rdwr_cnt", 64'(p1_cnt), 64'(17));
    send(16'hC301, 0);
    check("t4_full_drop_ovf", 64'(overflow), 64'(1));
    check("t4_full_drop_cnt", 64'(p1_cnt), 64'(17));
    step(); step(); step();
    check("t4_ovf_sticky", 64'(overflow), 64'(1));

    // Valid in IDLE is dropped and flagged.
    do_reset();
    check("t5_ovf_cleared", 64'(overflow), 64'(0));
    send(16'hF000, 1);
    check("t5_idle_ovf", 64'(overflow), 64'(1));
    check("t5_idle_counts", 64'({p1_cnt, p2_cnt, root_vld, run_done}), 64'(0));

    // Async reset while a coupler pair is half built.
    do_reset();
    start_run(1);
    send(16'h9000, 0);
    send(16'h9001, 0);
    send(16'h9002, 0);
    check("t6_pre_cp_vld", 64'(cp_vld), 64'(1));
    #1 rst = 1;
    #1;
    check("t6_rst_outputs", 64'({cp_vld, root_vld, phase, ml_read, busy, overflow}), 64'(0));
    check("t6_rst_counts", 64'({p1_cnt, p2_cnt}), 64'(0));
    step();
    rst = 0;
    step();
    check("t6_post_empty", 64'({cp_vld, root_vld}), 64'(0));
    start_run(1);
    send(16'h9009, 1);
    check("t6_fresh_word", 64'(cp_data), 64'({1'b1, 16'h0000, 16'h9009}));
    check("t6_p2_cnt", 64'(p2_cnt), 64'(1));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
